// File: rtl/proyecto2_pkg.sv
// Shared definitions for the FIFO pop arbiter: FSM encodings, default FIFO
// count and the index-width helper.
package proyecto2_pkg;

  localparam int NUM_FIFOS_DEF = 5;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_PAUSE  = 2'd2;

  // Width needed to hold an index in 0..n-1; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pop_arbiter_rr_grant.sv
// Combinational round-robin picker: first set bit of req searching upward
// from ptr+1 with wrap-around.
module rr_grant #(
  parameter int N  = 5,
  parameter int IW = 3
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  always_comb begin
    int j;
    j       = 0;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && req[j]) begin
        any     = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = IW'(j);
      end
    end
  end

endmodule

// File: rtl/pop_arbiter.sv
// Round-robin pop scheduler draining NUM_FIFOS FIFOs onto one tagged stream.
// Define POP_ARB_PRIO0_EN to give FIFO 0 strict priority over the rotation.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  ST_IDLE   | nothing pending, pipeline drained, idle asserted
//  ST_ACTIVE | popping / draining words
//  ST_PAUSE  | downstream almost-full, new pops held off
module pop_arbiter
  import proyecto2_pkg::*;
#(
  parameter  int NUM_FIFOS = NUM_FIFOS_DEF,
  parameter  int DATA_W    = 6,
  localparam int IDX_W     = idx_w(NUM_FIFOS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_FIFOS-1:0]        fifo_empty,
  input  logic [NUM_FIFOS*DATA_W-1:0] fifo_data,
  input  logic                        pause,
  output logic [NUM_FIFOS-1:0]        pop,
  output logic                        valid_out,
  output logic [DATA_W-1:0]           data_out,
  output logic [IDX_W-1:0]            src_idx,
  output logic                        idle
);

  logic [1:0]           state, state_nxt;
  logic [NUM_FIFOS-1:0] req, rr_req, rr_gnt, gnt;
  logic [IDX_W-1:0]     rr_idx, gnt_idx, rr_ptr;
  logic                 rr_any, gnt_any, pop_en, ptr_upd;
  logic                 any_req, pipe_empty;
  logic                 s1_v;
  logic [IDX_W-1:0]     s1_idx;

  assign req    = ~fifo_empty;
  assign pop_en = ~pause & ~reset;

  rr_grant #(
    .N  (NUM_FIFOS),
    .IW (IDX_W)
  ) u_rr_grant (
    .req     (rr_req),
    .ptr     (rr_ptr),
    .gnt     (rr_gnt),
    .gnt_idx (rr_idx),
    .any     (rr_any)
  );

`ifdef POP_ARB_PRIO0_EN
  // FIFO 0 bypasses the rotation and leaves the pointer untouched.
  assign rr_req  = req & {{(NUM_FIFOS-1){1'b1}}, 1'b0};
  assign gnt     = req[0] ? {{(NUM_FIFOS-1){1'b0}}, 1'b1} : rr_gnt;
  assign gnt_idx = req[0] ? '0 : rr_idx;
  assign gnt_any = req[0] | rr_any;
  assign ptr_upd = pop_en & rr_any & ~req[0];
`else
  assign rr_req  = req;
  assign gnt     = rr_gnt;
  assign gnt_idx = rr_idx;
  assign gnt_any = rr_any;
  assign ptr_upd = pop_en & rr_any;
`endif

  assign pop = (pop_en && gnt_any) ? gnt : '0;

  assign any_req    = |req;
  assign pipe_empty = ~s1_v & ~valid_out;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (any_req && !pause) state_nxt = ST_ACTIVE;
      ST_ACTIVE: begin
        if (pause)                         state_nxt = ST_PAUSE;
        else if (!any_req && pipe_empty)   state_nxt = ST_IDLE;
      end
      ST_PAUSE: begin
        if (!pause) begin
          if (any_req)                     state_nxt = ST_ACTIVE;
          else if (pipe_empty)             state_nxt = ST_IDLE;
        end
      end
      default:                             state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      idle      <= 1'b1;
      rr_ptr    <= IDX_W'(NUM_FIFOS - 1);
      s1_v      <= 1'b0;
      s1_idx    <= '0;
      valid_out <= 1'b0;
      data_out  <= '0;
      src_idx   <= '0;
    end else begin
      state <= state_nxt;
      idle  <= (state_nxt == ST_IDLE);
      if (ptr_upd) rr_ptr <= gnt_idx;
      s1_v <= |pop;
      if (|pop) s1_idx <= gnt_idx;
      // FIFO read data is presented the cycle after the pop strobe.
      valid_out <= s1_v;
      if (s1_v) begin
        data_out <= fifo_data[int'(s1_idx)*DATA_W +: DATA_W];
        src_idx  <= s1_idx;
      end
    end
  end

endmodule

// File: tb/tb_pop_arbiter.sv
// Bench for pop_arbiter: FIFO bank model, directed pop sequences and a
// scoreboard monitor on the tagged output stream.
module tb_pop_arbiter;
  import proyecto2_pkg::*;

  localparam int NF = 5;
  localparam int DW = 6;
  localparam int IW = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             pause = 1'b0;
  logic [NF-1:0]    fifo_empty;
  logic [NF*DW-1:0] fifo_data;
  logic [NF-1:0]    pop;
  logic             valid_out;
  logic [DW-1:0]    data_out;
  logic [IW-1:0]    src_idx;
  logic             idle;

  int errors = 0;
  int checks = 0;
  int valid_cnt = 0;

  logic [DW-1:0]    mem [NF][32];
  int               head [NF];
  int               tail [NF];
  logic [IW+DW-1:0] exp_q [$];
  logic [NF-1:0]    pop_seen = '0;

  pop_arbiter #(.NUM_FIFOS(NF), .DATA_W(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .pause      (pause),
    .pop        (pop),
    .valid_out  (valid_out),
    .data_out   (data_out),
    .src_idx    (src_idx),
    .idle       (idle)
  );

  always #5 clk = ~clk;

  function automatic void refresh();
    for (int i = 0; i < NF; i++) fifo_empty[i] = (head[i] == tail[i]);
  endfunction

  task automatic load(input int f, input int n);
    for (int k = 0; k < n; k++) begin
      mem[f][tail[f]] = DW'(f * 11 + tail[f] * 7 + 5);
      tail[f]++;
    end
    refresh();
  endtask

  // FIFO bank: pop strobes seen before an edge take effect just after it.
  always @(negedge clk) begin
    pop_seen = pop;
    checks++;
    if (!$onehot0(pop)) begin
      errors++;
      $display("FAIL onehot: pop=%b", pop);
    end
  end

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NF; i++) begin
      if (pop_seen[i]) begin
        checks++;
        if (head[i] == tail[i]) begin
          errors++;
          $display("FAIL pop_empty: fifo %0d popped while empty", i);
        end else begin
          fifo_data[i*DW +: DW] = mem[i][head[i]];
          exp_q.push_back({IW'(i), mem[i][head[i]]});
          head[i]++;
        end
      end
    end
    refresh();
  end

  // Scoreboard monitor; a reset drops whatever is still in flight.
  always @(negedge clk) begin
    logic [IW+DW-1:0] e;
    if (valid_out === 1'b1) begin
      valid_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL stream: unexpected word src=%0d data=%0d", src_idx, data_out);
      end else begin
        e = exp_q.pop_front();
        if ({src_idx, data_out} !== e) begin
          errors++;
          $display("FAIL stream: got src=%0d data=%0d expected src=%0d data=%0d",
                   src_idx, data_out, e[IW+DW-1:DW], e[DW-1:0]);
        end
      end
    end
    if (reset) exp_q.delete();
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input logic [31:0] act, input logic [31:0] exp, input string nm);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_pop(input logic [NF-1:0] e, input string nm);
    #1;
    checks++;
    if (pop !== e) begin
      errors++;
      $display("FAIL %s: pop=%b expected %b", nm, pop, e);
    end
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (idle !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk(32'(idle), 32'd1, nm);
  endtask

`ifdef POP_ARB_PRIO0_EN
  logic [NF-1:0] seq2 [10] = '{5'h01, 5'h01, 5'h02, 5'h04, 5'h08, 5'h10, 5'h02, 5'h04, 5'h08, 5'h10};
  logic [NF-1:0] seq4a [3] = '{5'h01, 5'h01, 5'h01};
  logic [NF-1:0] seq4b [12] = '{5'h08, 5'h10, 5'h02, 5'h04, 5'h08, 5'h10,
                                5'h02, 5'h04, 5'h08, 5'h10, 5'h02, 5'h04};
  logic [NF-1:0] seq5 [2] = '{5'h01, 5'h01};
  logic [NF-1:0] seq6 [5] = '{5'h01, 5'h01, 5'h01, 5'h08, 5'h08};
`else
  logic [NF-1:0] seq2 [10] = '{5'h01, 5'h02, 5'h04, 5'h08, 5'h10, 5'h01, 5'h02, 5'h04, 5'h08, 5'h10};
  logic [NF-1:0] seq4a [3] = '{5'h08, 5'h10, 5'h01};
  logic [NF-1:0] seq4b [12] = '{5'h02, 5'h04, 5'h08, 5'h10, 5'h01, 5'h02,
                                5'h04, 5'h08, 5'h10, 5'h01, 5'h02, 5'h04};
  logic [NF-1:0] seq5 [2] = '{5'h08, 5'h10};
  logic [NF-1:0] seq6 [5] = '{5'h01, 5'h08, 5'h01, 5'h08, 5'h01};
`endif

  initial begin
    int base;
    fifo_data = '0;
    for (int i = 0; i < NF; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    refresh();
    for (int f = 0; f < NF; f++) load(f, 2);

    // reset held with every FIFO non-empty
    repeat (2) begin
      step();
      chk_pop('0, "rst_pop");
      chk(32'(valid_out), 32'd0, "rst_valid");
      chk(32'(idle), 32'd1, "rst_idle");
    end
    step();
    reset = 1'b0;

    // full rotation, two words per FIFO
    base = valid_cnt;
    for (int k = 0; k < 10; k++) begin
      chk_pop(seq2[k], $sformatf("rr_seq%0d", k));
      step();
    end
    chk_pop('0, "rr_drained");
    chk(32'(idle), 32'd0, "rr_busy");
    wait_idle("rr_idle");
    chk(32'(valid_cnt - base), 32'd10, "rr_count");

    // sole requester popped back to back
    base = valid_cnt;
    load(2, 3);
    for (int k = 0; k < 3; k++) begin
      chk_pop(5'h04, $sformatf("solo%0d", k));
      step();
    end
    chk_pop('0, "solo_done");
    chk(32'(idle), 32'd0, "solo_busy");
    wait_idle("solo_idle");
    chk(32'(valid_cnt - base), 32'd3, "solo_count");

    // pause mid-stream, then resume without skipping
    for (int f = 0; f < NF; f++) load(f, 3);
    for (int k = 0; k < 3; k++) begin
      chk_pop(seq4a[k], $sformatf("pre_pause%0d", k));
      step();
    end
    pause = 1'b1;
    base = valid_cnt;
    for (int k = 0; k < 5; k++) begin
      chk_pop('0, $sformatf("paused%0d", k));
      step();
    end
    chk(32'(valid_cnt - base), 32'd2, "pause_inflight");
    pause = 1'b0;
    for (int k = 0; k < 12; k++) begin
      chk_pop(seq4b[k], $sformatf("resume%0d", k));
      step();
    end
    chk_pop('0, "resume_done");
    wait_idle("pause_idle");
    chk(32'(exp_q.size()), 32'd0, "pause_queue");

    // reset while words are in flight
    for (int f = 0; f < NF; f++) load(f, 3);
    for (int k = 0; k < 2; k++) begin
      chk_pop(seq5[k], $sformatf("pre_rst%0d", k));
      step();
    end
    reset = 1'b1;
    chk_pop('0, "rst_gate");
    step();
    reset = 1'b0;
    chk_pop(5'h01, "post_rst_pop");
    chk(32'(valid_out), 32'd0, "post_rst_valid");
    chk(32'(idle), 32'd1, "post_rst_idle");
    step();
    wait_idle("rst_drain_idle");
    chk(32'(exp_q.size()), 32'd0, "rst_queue");

    // FIFO 0 versus FIFO 3 from a fresh pointer
    reset = 1'b1;
    step();
    reset = 1'b0;
    load(0, 3);
    load(3, 2);
    for (int k = 0; k < 5; k++) begin
      chk_pop(seq6[k], $sformatf("prio%0d", k));
      step();
    end
    chk_pop('0, "prio_done");
    wait_idle("prio_idle");
    chk(32'(exp_q.size()), 32'd0, "final_queue");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: bench did not complete");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
